// File: rtl/bp_pkg.sv
// Shared types for the branch resolve path: prediction entry layout and
// resolve FSM states.
package bp_pkg;

  localparam int PC_W  = 4;
  localparam int GHR_W = 2;

  localparam logic [7:0] COUNT_MAX = 8'd255;

  typedef struct packed {
    logic             taken;
    logic [PC_W-1:0]  pc;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order prediction queue: synchronous FIFO with push/pop/clear, where a
// pop in the same cycle frees the slot for a push into a full queue.
module pred_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign head      = mem_r[rptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointers wrap naturally because DEPTH is a power of two; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= PW'(0);
      rptr_r  <= PW'(0);
      count_r <= CW'(0);
    end else if (clear) begin
      wptr_r  <= PW'(0);
      rptr_r  <= PW'(0);
      count_r <= CW'(0);
    end else begin
      if (do_push_s) wptr_r <= wptr_r + PW'(1);
      if (do_pop_s)  rptr_r <= rptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) mem_r[wptr_r] <= din;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued predictions against execute outcomes, drives predictor
// training, mispredict pulse, recovery stall and a saturating mispredict count.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Pred_Valid,
  output logic             Pred_Ready,
  input  logic             Pred_Taken,
  input  logic [PC_W-1:0]  Pred_PC,
  input  logic [GHR_W-1:0] Pred_GHR,
  input  logic             Resolve_Valid,
  output logic             Resolve_Ready,
  input  logic             Resolve_Taken,
  output logic             Update_Valid,
  output logic [PC_W-1:0]  Update_PC,
  output logic [GHR_W-1:0] Update_GHR,
  output logic             Update_Taken,
  output logic             Mispredict,
  output logic             Stall,
  output logic [7:0]       Mispredict_Count
);

  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  state_e        state_r;
  logic [RW-1:0] rec_cnt_r;
  entry_t        head_s;
  entry_t        push_entry_s;
  logic          full_s;
  logic          empty_s;
  logic          in_run_s;
  logic          pop_s;
  logic          push_s;
  logic          mismatch_s;

  assign in_run_s     = (state_r == RUN);
  assign pop_s        = Resolve_Valid && !empty_s;
  assign mismatch_s   = pop_s && (head_s.taken != Resolve_Taken);
  // Acceptance may use a same-cycle pop; the Ready output may not, so it never depends on a Valid input.
  assign push_s       = Pred_Valid && in_run_s && (!full_s || pop_s);
  assign push_entry_s = '{taken: Pred_Taken, pc: Pred_PC, ghr: Pred_GHR};

  assign Pred_Ready    = in_run_s && !full_s;
  assign Resolve_Ready = !empty_s;
  assign Stall         = (state_r == RECOVER);

  pred_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .clear (mismatch_s),
    .din   (push_entry_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Recovery FSM: a mismatch parks fetch for exactly RECOVER_CYCLES cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= RUN;
      rec_cnt_r <= RW'(0);
    end else begin
      case (state_r)
        RUN: begin
          if (mismatch_s) begin
            state_r   <= RECOVER;
            rec_cnt_r <= RW'(RECOVER_CYCLES - 1);
          end
        end
        RECOVER: begin
          if (rec_cnt_r == RW'(0)) begin
            state_r <= RUN;
          end else begin
            rec_cnt_r <= rec_cnt_r - RW'(1);
          end
        end
        default: begin
          state_r   <= RUN;
          rec_cnt_r <= RW'(0);
        end
      endcase
    end
  end

  // Training write, mispredict pulse and saturating counter, one cycle after the pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Update_Valid     <= 1'b0;
      Update_PC        <= PC_W'(0);
      Update_GHR       <= GHR_W'(0);
      Update_Taken     <= 1'b0;
      Mispredict       <= 1'b0;
      Mispredict_Count <= 8'd0;
    end else begin
      Update_Valid <= pop_s;
      Mispredict   <= mismatch_s;
      if (pop_s) begin
        Update_PC    <= head_s.pc;
        Update_GHR   <= head_s.ghr;
        Update_Taken <= Resolve_Taken;
      end
      if (mismatch_s && (Mispredict_Count != COUNT_MAX)) begin
        Mispredict_Count <= Mispredict_Count + 8'd1;
      end
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side companion to the branch predictor. Holds each issued prediction in an in-order queue, compares it with the outcome reported by execute, and produces the predictor training write, a mispredict pulse and a fetch stall for pipeline recovery. Sits between fetch (prediction push), execute (outcome pop) and the predictor's history tables (update port).

## Interface
Parameters:
- DEPTH, 4, prediction queue entries (power of two, ≥2)
- RECOVER_CYCLES, 2, stall cycles after a mispredict (≥1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- Pred_Valid  in  1  fetch pushes a prediction
- Pred_Ready  out  1  queue accepts push
- Pred_Taken  in  1  predicted direction
- Pred_PC  in  4  branch PC index
- Pred_GHR  in  2  global history used for the prediction
- Resolve_Valid  in  1  execute reports oldest branch outcome
- Resolve_Ready  out  1  queue non-empty
- Resolve_Taken  in  1  actual direction
- Update_Valid  out  1  predictor training strobe
- Update_PC  out  4  index to train
- Update_GHR  out  2  history to train
- Update_Taken  out  1  actual direction
- Mispredict  out  1  one-cycle mispredict pulse
- Stall  out  1  fetch stall during recovery
- Mispredict_Count  out  8  saturating mispredict counter

## Operation
- Push accepted when Pred_Valid && Pred_Ready; pop when Resolve_Valid && Resolve_Ready. Entry = {Taken, PC, GHR}.
- Pred_Ready = !full && state==RUN, counting a same-cycle pop (full + pop ⇒ push accepted).
- Resolve_Ready = !empty. Resolve while empty: ignored, no outputs.
- Every pop: Update_* registered from head entry PC/GHR and Resolve_Taken; Update_Valid pulses one cycle.
- Mismatch (head Taken ≠ Resolve_Taken): Mispredict pulses, entire queue cleared (including same-cycle push), Mispredict_Count += 1 saturating at 255, state → RECOVER.
- FSM: RUN → RECOVER on mismatch; RECOVER holds RECOVER_CYCLES cycles (down-counter), then → RUN. Stall = (state==RECOVER). In RECOVER, Pred_Ready=0; Resolve_Ready=0 (queue empty).
- Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
- RST mid-operation: queue emptied, FSM → RUN, counter cleared immediately.

## Timing
- Reset values: Pred_Ready=1, Resolve_Ready=0, Update_Valid=0, Update_PC=0, Update_GHR=0, Update_Taken=0, Mispredict=0, Stall=0, Mispredict_Count=0.
- Pop in cycle N ⇒ Update_*/Mispredict valid in cycle N+1 (one-cycle latency, registered).
- Mismatch pop in cycle N ⇒ Stall high cycles N+1 … N+RECOVER_CYCLES; Pred_Ready high again in N+RECOVER_CYCLES+1.
- Push in cycle N ⇒ Resolve_Ready high in N+1 (no fall-through).
- Ready signals combinational from registered state only; no combinational path from Valid inputs to Ready outputs.

## Structure
- Shared package bp_pkg: PC index width (4), GHR width (2), entry struct {taken, pc, ghr}, FSM state enum {RUN, RECOVER}.
- One sub-module: pred_queue — synchronous FIFO with push/pop/clear, full/empty, simultaneous push+pop support. FSM, compare, counter and update registers in the top.

## Test plan
- Reset: assert RST mid-stream with 3 entries → all outputs at reset values asynchronously; Pred_Ready=1 next cycle.
- Correct prediction: push {Taken=1, PC=4'h5, GHR=2'b10}, resolve Taken=1 → next cycle Update_Valid=1, Update_PC=5, Update_GHR=2, Update_Taken=1, Mispredict=0, Stall=0.
- Mispredict: push 3 entries, first predicted Taken=0, resolve Taken=1 → Mispredict pulse, Mispredict_Count=1, Stall high exactly 2 cycles, Resolve_Ready=0, remaining entries discarded.
- Full: push 4 with no pop → Pred_Ready=0, 5th push dropped; push+pop same cycle while full → both accepted, occupancy stays 4, order preserved.
- Empty/corner: Resolve_Valid with empty queue → no Update_Valid; push coincident with mismatch pop → push discarded.
- Saturation: 260 consecutive mispredicts → Mispredict_Count holds 255.
